// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helper for the debounce filter.
// Latency: none (constants only). Backpressure: not applicable.
// Build option DEBOUNCE_EDGE_PULSE_EN is consumed by debounce.sv.
package debounce_pkg;

   localparam int DEBOUNCE_STABLE_CYCLES_DEF = 5000;
   localparam int DEBOUNCE_SYNC_STAGES_DEF   = 2;

   // Counter must hold STABLE_CYCLES-1 without wrapping.
   function automatic int debounce_cnt_width(input int stable_cycles);
      return $clog2(stable_cycles + 1);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser with a synchronous reset value.
// Latency: N clocks from d to q. Backpressure: none, free-running.
module sync_ff #(
   parameter int   N           = 2,
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [N-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {N{RESET_VALUE}};
      end else begin
         chain <= {chain[N-2:0], d};
      end
   end

   assign q = chain[N-1];

endmodule

// File: rtl/debounce.sv
// Debounces a raw pin into a clean flop-driven level; DEBOUNCE_EDGE_PULSE_EN adds edge pulses.
// Latency: SYNC_STAGES+STABLE_CYCLES edges from first sampling edge. Backpressure: none.
module debounce
   import debounce_pkg::*;
#(
   parameter int   STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES_DEF,
   parameter int   SYNC_STAGES   = DEBOUNCE_SYNC_STAGES_DEF,
   parameter logic RESET_VALUE   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic signal_in,
   output logic signal_out
`ifdef DEBOUNCE_EDGE_PULSE_EN
   ,
   output logic rise_pulse,
   output logic fall_pulse
`endif
);

   localparam int            CW        = debounce_cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);

   logic          sync;
   logic [CW-1:0] cnt;

   sync_ff #(
      .N           (SYNC_STAGES),
      .RESET_VALUE (RESET_VALUE)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (signal_in),
      .q   (sync)
   );

   // Any cycle where the synced level agrees with the output restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         signal_out <= RESET_VALUE;
      end else if (sync == signal_out) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         signal_out <= sync;
         cnt        <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

`ifdef DEBOUNCE_EDGE_PULSE_EN
   logic out_d;

   // out_d shares the reset value of signal_out, so reset alone never pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_d      <= RESET_VALUE;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         out_d      <= signal_out;
         rise_pulse <= signal_out & ~out_d;
         fall_pulse <= ~signal_out & out_d;
      end
   end
`endif

endmodule

// File: tb/tb_debounce.sv
// Randomised bench for debounce: a default instance and a STABLE_CYCLES=1 instance share one input.
// A reference model queues expected output changes; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_debounce;
   import debounce_pkg::*;

   localparam int S0 = DEBOUNCE_STABLE_CYCLES_DEF;
   localparam int S1 = 1;
   localparam int NS = DEBOUNCE_SYNC_STAGES_DEF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic signal_in = 1'b0;
   logic out0, out1;
`ifdef DEBOUNCE_EDGE_PULSE_EN
   logic rise0, fall0, rise1, fall1;
`endif

   always #20 clk = ~clk;

   debounce #(.STABLE_CYCLES(S0), .SYNC_STAGES(NS), .RESET_VALUE(1'b0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .signal_in  (signal_in),
      .signal_out (out0)
`ifdef DEBOUNCE_EDGE_PULSE_EN
      ,
      .rise_pulse (rise0),
      .fall_pulse (fall0)
`endif
   );

   debounce #(.STABLE_CYCLES(S1), .SYNC_STAGES(NS), .RESET_VALUE(1'b0)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .signal_in  (signal_in),
      .signal_out (out1)
`ifdef DEBOUNCE_EDGE_PULSE_EN
      ,
      .rise_pulse (rise1),
      .fall_pulse (fall1)
`endif
   );

   typedef struct {
      int   cyc;
      logic lvl;
   } evt_t;

   evt_t exp_q0[$];
   evt_t exp_q1[$];
   int   cyc       = 0;
   int   checks    = 0;
   int   errors    = 0;
   int   last_chg0 = -1;
   int   last_chg1 = -1;
   logic prev0     = 1'b0;
   logic prev1     = 1'b0;

   // Reference model state: a delay line standing in for the synchroniser, the
   // filtered level, and how many consecutive edges the delayed level disagreed.
   logic [NS-1:0] m_line   [2];
   logic          m_level  [2];
   int            m_streak [2];
`ifdef DEBOUNCE_EDGE_PULSE_EN
   logic          m_pend_rise [2];
   logic          m_pend_fall [2];
   logic          m_exp_rise  [2];
   logic          m_exp_fall  [2];
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_step(input int idx, input int stable);
      logic delayed, nxt;
      nxt = m_level[idx];
      if (rst) begin
         m_line[idx]   = '0;
         m_streak[idx] = 0;
         nxt           = 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
         m_exp_rise[idx]  = 1'b0;
         m_exp_fall[idx]  = 1'b0;
         m_pend_rise[idx] = 1'b0;
         m_pend_fall[idx] = 1'b0;
`endif
      end else begin
         delayed = m_line[idx][NS-1];
         if (delayed == m_level[idx]) begin
            m_streak[idx] = 0;
         end else begin
            m_streak[idx] = m_streak[idx] + 1;
            if (m_streak[idx] == stable) begin
               nxt           = delayed;
               m_streak[idx] = 0;
            end
         end
         m_line[idx] = {m_line[idx][NS-2:0], signal_in};
`ifdef DEBOUNCE_EDGE_PULSE_EN
         m_exp_rise[idx]  = m_pend_rise[idx];
         m_exp_fall[idx]  = m_pend_fall[idx];
         m_pend_rise[idx] = nxt & ~m_level[idx];
         m_pend_fall[idx] = ~nxt & m_level[idx];
`endif
      end
      if (nxt != m_level[idx]) begin
         if (idx == 0) exp_q0.push_back('{cyc: cyc, lvl: nxt});
         else          exp_q1.push_back('{cyc: cyc, lvl: nxt});
      end
      m_level[idx] = nxt;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_line[i]   = '0;
         m_level[i]  = 1'b0;
         m_streak[i] = 0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
         m_pend_rise[i] = 1'b0;
         m_pend_fall[i] = 1'b0;
         m_exp_rise[i]  = 1'b0;
         m_exp_fall[i]  = 1'b0;
`endif
      end
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         model_step(0, S0);
         model_step(1, S1);
      end
   end

   task automatic watch(input string tag, input logic now, ref logic prev,
                        ref evt_t q[$], ref int last_chg);
      evt_t e;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL %s missing change: output stayed %0b, expected %0b at edge %0d",
                  tag, now, q[0].lvl, q[0].cyc);
         void'(q.pop_front());
      end
      if (now !== prev) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected change: got %0b at edge %0d, expected no change",
                     tag, now, cyc);
         end else begin
            e = q.pop_front();
            check({tag, " change edge"}, cyc, e.cyc);
            check({tag, " change level"}, now, e.lvl);
         end
         last_chg = cyc;
         prev     = now;
      end
   endtask

   // Monitor: starts on the negedge at which reset is released.
   initial begin
      repeat (5) @(negedge clk);
      check("reset out0", out0, 1'b0);
      check("reset out1", out1, 1'b0);
`ifdef DEBOUNCE_EDGE_PULSE_EN
      check("reset rise0", rise0, 1'b0);
      check("reset fall0", fall0, 1'b0);
`endif
      forever begin
         @(negedge clk);
         watch("out0", out0, prev0, exp_q0, last_chg0);
         watch("out1", out1, prev1, exp_q1, last_chg1);
`ifdef DEBOUNCE_EDGE_PULSE_EN
         check("rise0", rise0, m_exp_rise[0]);
         check("fall0", fall0, m_exp_fall[0]);
         check("rise1", rise1, m_exp_rise[1]);
         check("fall1", fall1, m_exp_fall[1]);
`endif
      end
   end

   task automatic hold(input logic v, input int n);
      signal_in = v;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int t0;
      int len;
      rst       = 1'b1;
      signal_in = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;

      // Bounce at 250-clock intervals: too short for the default filter.
      for (int i = 0; i < 4; i++) hold(i % 2 == 0, 250);
      check("bounce out0", out0, 1'b0);

      // Clean hold with exact latency, then alternating holds.
      t0 = cyc + 1;
      hold(1'b1, S0 + 100);
      check("rise latency dut0", last_chg0, t0 + NS + S0 - 1);
      check("rise latency dut1", last_chg1, t0 + NS + S1 - 1);
      t0 = cyc + 1;
      hold(1'b0, S0 + 100);
      check("fall latency dut0", last_chg0, t0 + NS + S0 - 1);
      hold(1'b1, S0 + 100);
      hold(1'b0, S0 + 100);
      check("after holds out0", out0, 1'b0);

      // One clock short of the threshold, then exactly at it.
      hold(1'b1, S0 - 1);
      hold(1'b0, 200);
      check("near miss out0", out0, 1'b0);
      hold(1'b1, S0);
      hold(1'b0, S0 + 100);

      // Reset part-way through a count discards it.
      hold(1'b1, NS + 3000);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("mid reset out0", out0, 1'b0);
      check("mid reset out1", out1, 1'b0);
      rst = 1'b0;
      t0  = cyc + 1;
      repeat (S0 + 100) @(negedge clk);
      check("post reset latency dut0", last_chg0, t0 + NS + S0 - 1);
      check("post reset latency dut1", last_chg1, t0 + NS + S1 - 1);
      hold(1'b0, S0 + 100);

      // Random segments: mostly short glitches, a few near the threshold.
      for (int i = 0; i < 10; i++) begin
         if (i % 4 == 1) len = $urandom_range(S0 + 200, S0 - 5);
         else            len = $urandom_range(300, 1);
         hold(~signal_in, len);
      end
      hold(1'b0, S0 + NS + 20);

      check("queue0 drained", exp_q0.size(), 0);
      check("queue1 drained", exp_q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
